// File: rtl/cache_mem_pkg.sv
// Shared constants and FSM state encoding for the cache <-> physical memory line adaptor.
package cache_mem_pkg;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Moves 256-bit cache lines to/from physical memory as four 64-bit bursts,
// one transaction at a time.
module cacheline_adaptor
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET_BITS) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  mem_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] asm_line;
  logic [LINE_W-1:0] wr_line;

  wire last_beat = resp_i && (cnt == LAST_BEAT);

  // Control outputs decode directly off the state register, so an async
  // reset drops them immediately.
  assign read_o  = (state == READ);
  assign write_o = (state == WRITE);
  assign resp_o  = (state == DONE);
  assign burst_o = wr_line[int'(cnt)*BEAT_W +: BEAT_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      asm_line  <= '0;
      wr_line   <= '0;
      line_o    <= '0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            wr_line   <= line_i;
            address_o <= address_i & LINE_MASK;
            cnt       <= '0;
            state     <= WRITE;
          end else if (read_i) begin
            address_o <= address_i & LINE_MASK;
            cnt       <= '0;
            state     <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            asm_line[int'(cnt)*BEAT_W +: BEAT_W] <= burst_i;
            cnt <= cnt + CNT_W'(1);
          end
          // line_o only changes when a fill completes; the top slice comes
          // straight from the bus on the final beat.
          if (last_beat) begin
            line_o <= {burst_i, asm_line[LINE_W-BEAT_W-1:0]};
            state  <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) cnt <= cnt + CNT_W'(1);
          if (last_beat) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor.
module tb_cacheline_adaptor;
  import cache_mem_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] address_i;
  logic              read_i, write_i;
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic              resp_o;
  logic [ADDR_W-1:0] address_o;
  logic              read_o, write_o;
  logic [BEAT_W-1:0] burst_o;
  logic [BEAT_W-1:0] burst_i;
  logic              resp_i;

  int n_cmp = 0;
  int n_bad = 0;

  cacheline_adaptor #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; address_i = '0; read_i = 0; write_i = 0;
    line_i = '0; burst_i = '0; resp_i = 0;
    tick(); tick();
    n_cmp++;
    if ({resp_o, read_o, write_o} !== 3'b000 || line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: resp=%b rd=%b wr=%b line=%h burst=%h addr=%h, need all 0",
               resp_o, read_o, write_o, line_o, burst_o, address_o);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resp_i = i[0];
      tick();
      n_cmp++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_resp_toggle: rd=%b wr=%b resp=%b, need 0 0 0", read_o, write_o, resp_o);
      end
    end
    resp_i = 0;
  endtask

  task automatic test_fill();
    logic [BEAT_W-1:0] b [4];
    b[0] = {16{4'h1}}; b[1] = {16{4'h2}}; b[2] = {16{4'h3}}; b[3] = {16{4'h4}};
    address_i = 32'h0000_1234; read_i = 1;
    tick(); // E0
    read_i = 0;
    n_cmp++;
    if (address_o !== 32'h0000_1220 || read_o !== 1'b1 || write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_start: addr=%h rd=%b wr=%b, need 00001220 1 0", address_o, read_o, write_o);
    end
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = b[i];
      tick();
      if (i < 3) begin
        n_cmp++;
        if (resp_o !== 1'b0 || read_o !== 1'b1) begin
          n_bad++;
          $display("FAIL fill_early_resp: beat %0d resp=%b rd=%b, need 0 1", i, resp_o, read_o);
        end
      end
    end
    resp_i = 0; burst_i = '0;
    n_cmp++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 ||
        line_o !== {b[3], b[2], b[1], b[0]}) begin
      n_bad++;
      $display("FAIL fill_done: resp=%b rd=%b line=%h, need 1 0 %h",
               resp_o, read_o, line_o, {b[3], b[2], b[1], b[0]});
    end
    tick();
    n_cmp++;
    if (resp_o !== 1'b0 || line_o !== {b[3], b[2], b[1], b[0]}) begin
      n_bad++;
      $display("FAIL fill_resp_pulse: resp=%b line=%h, need 0 and held line", resp_o, line_o);
    end
  endtask

  task automatic test_writeback();
    logic [BEAT_W-1:0] a [4];
    logic [3:0] pat;
    logic [BEAT_W-1:0] exp [6];
    a[0] = {16{4'hA}} ^ 64'h0; a[1] = {8{8'hA1}}; a[2] = {8{8'hA2}}; a[3] = {8{8'hA3}};
    pat = 4'b0;
    line_i = {a[3], a[2], a[1], a[0]};
    address_i = 32'h8000_00FF; write_i = 1;
    tick();
    write_i = 0;
    n_cmp++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== a[0] || address_o !== 32'h8000_00E0) begin
      n_bad++;
      $display("FAIL wb_start: wr=%b rd=%b burst=%h addr=%h, need 1 0 %h 800000e0",
               write_o, read_o, burst_o, address_o, a[0]);
    end
    // resp_i: 1,0,0,1,1 then final 1; burst_o after each edge
    exp[0] = a[1]; exp[1] = a[1]; exp[2] = a[1]; exp[3] = a[2]; exp[4] = a[3];
    for (int i = 0; i < 5; i++) begin
      resp_i = (i == 0 || i >= 3);
      tick();
      n_cmp++;
      if (burst_o !== exp[i] || write_o !== 1'b1 || resp_o !== 1'b0) begin
        n_bad++;
        $display("FAIL wb_beat%0d: burst=%h wr=%b resp=%b, need %h 1 0",
                 i, burst_o, write_o, resp_o, exp[i]);
      end
    end
    resp_i = 1;
    tick();
    resp_i = 0;
    n_cmp++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_done: resp=%b wr=%b, need 1 0", resp_o, write_o);
    end
    tick();
    n_cmp++;
    if (resp_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_resp_pulse: resp=%b, need 0", resp_o);
    end
    pat = '0;
  endtask

  task automatic test_collision();
    line_i = {4{64'h0123_4567_89AB_CDEF}};
    address_i = 32'h0000_0040; read_i = 1; write_i = 1;
    tick();
    write_i = 0;
    n_cmp++;
    if (write_o !== 1'b1 || read_o !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_prio: wr=%b rd=%b, need 1 0", write_o, read_o);
    end
    for (int i = 0; i < 4; i++) begin
      read_i = ~read_i; resp_i = 1;
      tick();
      if (i < 3) begin
        n_cmp++;
        if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== 32'h0000_0040) begin
          n_bad++;
          $display("FAIL collide_hold%0d: wr=%b rd=%b addr=%h, need 1 0 00000040",
                   i, write_o, read_o, address_o);
        end
      end
    end
    resp_i = 0; read_i = 0;
    n_cmp++;
    if (resp_o !== 1'b1) begin
      n_bad++;
      $display("FAIL collide_done: resp=%b, need 1", resp_o);
    end
    tick();
    tick();
    n_cmp++;
    if (read_o !== 1'b0 || write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_idle: rd=%b wr=%b, need 0 0", read_o, write_o);
    end
  endtask

  task automatic test_reset_midop();
    logic [BEAT_W-1:0] b [4];
    b[0] = 64'hDEAD_0000_0000_0001; b[1] = 64'hDEAD_0000_0000_0002;
    b[2] = 64'hBEEF_0000_0000_0003; b[3] = 64'hBEEF_0000_0000_0004;
    address_i = 32'h0000_2000; read_i = 1;
    tick();
    read_i = 0;
    resp_i = 1; burst_i = 64'h5555_5555_5555_5555; tick();
    burst_i = 64'h6666_6666_6666_6666; tick();
    resp_i = 0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (read_o !== 1'b0 || address_o !== '0 || line_o !== '0) begin
      n_bad++;
      $display("FAIL midop_async: rd=%b addr=%h line=%h, need 0 0 0", read_o, address_o, line_o);
    end
    tick();
    reset_n = 1'b1;
    tick();
    address_i = 32'h0000_3010; read_i = 1;
    tick();
    read_i = 0;
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = b[i]; tick();
    end
    resp_i = 0;
    n_cmp++;
    if (resp_o !== 1'b1 || address_o !== 32'h0000_3000 || line_o !== {b[3], b[2], b[1], b[0]}) begin
      n_bad++;
      $display("FAIL midop_refill: resp=%b addr=%h line=%h, need 1 00003000 %h",
               resp_o, address_o, line_o, {b[3], b[2], b[1], b[0]});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    address_i = 32'h0000_0100; read_i = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = 64'(i + 16); tick();
      pulses += int'(resp_o);
    end
    resp_i = 0;
    tick();
    pulses += int'(resp_o);
    n_cmp++;
    if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle_gap: rd=%b resp=%b, need 0 0", read_o, resp_o);
    end
    tick();
    read_i = 0;
    n_cmp++;
    if (read_o !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second_start: rd=%b, need 1", read_o);
    end
    for (int i = 0; i < 4; i++) begin
      resp_i = 1; burst_i = 64'(i + 32); tick();
      pulses += int'(resp_o);
    end
    resp_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(resp_o);
    end
    n_cmp++;
    if (pulses != 2 || line_o !== {64'd35, 64'd34, 64'd33, 64'd32}) begin
      n_bad++;
      $display("FAIL b2b_pulses: pulses=%0d line=%h, need 2 and 0..23_0..22_0..21_0..20", pulses, line_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_collision();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
